ccd_pixel_sampler: RTL
======================

# ccd_pixel_sampler

Captures one 2×2 Bayer quad at a selectable coordinate from the raw CCD pixel stream. It demosaics the quad to 8-bit R/G/B and holds the result stable for a full frame. It sits between the camera front-end and the system's `camera_red_in` / `camera_green_in` / `camera_blue_in` PIO inputs, so the processor reads a coherent, tear-free pixel.

## Interface
- `DATA_W`, 12: raw CCD sample width.
- `COORD_W`, 11: width of the x/y counters and quad coordinates.
- `OUT_W`, 8: width of each output colour channel.

- `clk_clk`, in, 1: system clock; the camera stream is already synchronous to it.
- `reset_reset`, in, 1: synchronous, active-high reset.
- `ccd_fval`, in, 1: frame valid.
- `ccd_lval`, in, 1: line valid.
- `ccd_dval`, in, 1: pixel qualifier; a sample is accepted only when `ccd_fval & ccd_lval & ccd_dval`.
- `ccd_data`, in, `DATA_W`: raw Bayer sample in GRBG order (even row G,R; odd row B,G).
- `quad_x`, in, `COORD_W-1`: quad column; pixel column = 2·`quad_x`.
- `quad_y`, in, `COORD_W-1`: quad row; pixel row = 2·`quad_y`.
- `red_out`, out, `OUT_W`: held red channel.
- `green_out`, out, `OUT_W`: held green channel.
- `blue_out`, out, `OUT_W`: held blue channel.
- `frame_done`, out, 1: one-cycle pulse when the outputs update.
- `quad_miss`, out, 1: sticky per frame; set when the last frame ended without capturing the full quad.
- `frame_count`, out, 8: count of committed frames; wraps from 255 to 0.

## Operation
- States:
  - WAIT_IDLE (reset state): wait for `ccd_fval`=0, then go to IDLE. This discards a partial frame.
  - IDLE: on a `ccd_fval` rising edge, latch `quad_x`/`quad_y`, clear x/y/capture flags, go to FRAME.
  - FRAME: count pixels and capture the quad; on a `ccd_fval` falling edge go to COMMIT.
  - COMMIT: single cycle, then IDLE.
- Counters:
  - x increments on each accepted sample and clears on `ccd_lval` falling.
  - y increments on `ccd_lval` falling only if x≠0 for that line.
  - Both saturate at all-ones; there is no wrap inside a frame.
- Capture: four DATA_W registers plus a 4-bit captured mask.
  - G1 at (2qx,2qy), R at (2qx+1,2qy), B at (2qx,2qy+1), G2 at (2qx+1,2qy+1).
- Demosaic, computed in COMMIT:
  - `red` = R[DATA_W-1 -: OUT_W].
  - `blue` = B[DATA_W-1 -: OUT_W].
  - `green` = (G1+G2), which is DATA_W+1 bits, then take bits [DATA_W -: OUT_W]. This truncates and does not round.
- Commit:
  - If mask = 4'b1111, load the outputs, clear `quad_miss`, increment `frame_count`, and pulse `frame_done`.
  - Otherwise hold the outputs, set `quad_miss`, and leave `frame_count` and `frame_done` unchanged.
- Coordinate changes mid-frame are ignored until the next `ccd_fval` rising edge.
- `ccd_lval` or `ccd_dval` while `ccd_fval`=0 is ignored.

## Timing
- Reset values: all colour outputs 0, `frame_done` 0, `quad_miss` 0, `frame_count` 0, state WAIT_IDLE.
- Edge detection uses `ccd_fval` registered by one cycle.
- `ccd_fval` falling is seen at cycle N. COMMIT is at N+1. Outputs and `frame_done` are valid at N+2.
- Outputs change only in the cycle following COMMIT; they never glitch mid-frame.
- `ccd_fval` rising during COMMIT is missed: that frame is skipped and the block waits in IDLE for the next rising edge.
- Reset asserted mid-frame aborts the capture, returns all outputs to reset values, and requires `ccd_fval` low before the next capture.
- A line that ends and a frame that ends in the same cycle: the y increment is irrelevant; commit proceeds normally.

## Configuration
- `CCD_SAMPLER_AVG_EN` defined: average a 2×2 block of quads (4×4 pixels) starting at the quad coordinate.
  - Four accumulators: R and B sums are DATA_W+2 bits; the G sum is DATA_W+3 bits.
  - Commit requires all 16 pixels captured.
  - Outputs are the top OUT_W bits of each sum, which equals sum/4 or sum/8 truncated.
- Not defined: single-quad capture as described above; no accumulators are synthesized.

## Structure
- Package `ccd_sampler_pkg` holds:
  - the state enum (WAIT_IDLE, IDLE, FRAME, COMMIT);
  - the Bayer position constants (G1, R, B, G2 index);
  - the default widths.
- One sub-module, `ccd_xy_counter`, holds the x/y counters, line/frame edge detection and saturation; it exports x, y, `sample_ok`, `frame_start` and `frame_end`.

## Test plan
- Reset, then one 8×4 frame with `ccd_data`=`{row,col}`·16 and quad (1,0) → `red_out`=`ccd_data`(0,3)[11:4], `green_out` = (G(0,2)+G(1,3))[12:5], `blue_out`=`ccd_data`(1,2)[11:4], `frame_done` pulse two cycles after `ccd_fval` falls, `frame_count`=1.
- All pixels 12'hFFF → red=blue=8'hFF, green=8'hFF (sum 13'h1FFE truncates to FF).
- Quad (10,10) on an 8×4 frame → `quad_miss`=1, outputs unchanged, `frame_count` unchanged, no `frame_done`.
- Change `quad_x` mid-frame from 1 to 2 → that frame commits quad 1; the next frame commits quad 2.
- Assert reset with `ccd_fval` high mid-frame, release while `ccd_fval` is still high → the rest of that frame is ignored; the next full frame commits with `frame_count`=1.
- Gapped `ccd_dval` (every other cycle) on a 4×2 frame → same outputs as the gap-free run.

Source files
------------

// File: rtl/ccd_sampler_pkg.sv
// Shared types and constants for the CCD pixel sampler: FSM states, Bayer slot indices,
// default widths and the capture block geometry (2x2 pixels, or 4x4 under CCD_SAMPLER_AVG_EN).
package ccd_sampler_pkg;

    localparam int DATA_W_DEF  = 12;
    localparam int COORD_W_DEF = 11;
    localparam int OUT_W_DEF   = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        FRAME     = 2'd2,
        COMMIT    = 2'd3
    } state_e;

    // Slot index is {row[0], col[0]} of a GRBG quad.
    localparam logic [1:0] POS_G1 = 2'd0;
    localparam logic [1:0] POS_R  = 2'd1;
    localparam logic [1:0] POS_B  = 2'd2;
    localparam logic [1:0] POS_G2 = 2'd3;

`ifdef CCD_SAMPLER_AVG_EN
    localparam int BLK_LOG2 = 2;
`else
    localparam int BLK_LOG2 = 1;
`endif
    localparam int NPIX = 1 << (2 * BLK_LOG2);

endpackage

// File: rtl/ccd_xy_counter.sv
// Pixel x/y position tracking for the raw CCD stream, with fval/lval edge detection.
// Both counters saturate at all-ones instead of wrapping.
module ccd_xy_counter #(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               clr_i,
    input  logic               fval_i,
    input  logic               lval_i,
    input  logic               dval_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               sample_ok_o,
    output logic               frame_start_o,
    output logic               frame_end_o
);

    logic               fval_q, lval_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               line_end;

    assign sample_ok_o   = fval_i & lval_i & dval_i;
    assign frame_start_o = fval_i & ~fval_q;
    assign frame_end_o   = ~fval_i & fval_q;
    // Line activity outside a frame is ignored.
    assign line_end      = fval_q & lval_q & ~lval_i;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (line_end) begin
            x_d = '0;
            if (x_q != '0 && y_q != '1)
                y_d = y_q + COORD_W'(1);
        end else if (sample_ok_o && x_q != '1) begin
            x_d = x_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            fval_q <= 1'b0;
            lval_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            fval_q <= fval_i;
            lval_q <= lval_i;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/ccd_pixel_sampler.sv
// Captures one Bayer quad (or a 2x2 block of quads with CCD_SAMPLER_AVG_EN defined) per frame,
// demosaics it to R/G/B and holds the result until the next complete capture.
module ccd_pixel_sampler
    import ccd_sampler_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               ccd_fval,
    input  logic               ccd_lval,
    input  logic               ccd_dval,
    input  logic [DATA_W-1:0]  ccd_data,
    input  logic [COORD_W-2:0] quad_x,
    input  logic [COORD_W-2:0] quad_y,
    output logic [OUT_W-1:0]   red_out,
    output logic [OUT_W-1:0]   green_out,
    output logic [OUT_W-1:0]   blue_out,
    output logic               frame_done,
    output logic               quad_miss,
    output logic [7:0]         frame_count
);

    state_e               state_q, state_d;
    logic                 start_cap, commit_en;
    logic [COORD_W-1:0]   x, y, rel_x, rel_y, org_x, org_y;
    logic                 sample_ok, frame_start, frame_end;
    logic [COORD_W-2:0]   qx_q, qy_q;
    logic                 in_blk, hit;
    logic [2*BLK_LOG2-1:0] pix_idx;
    logic [NPIX-1:0]      mask_q;
    logic [OUT_W-1:0]     red_c, green_c, blue_c;
    logic [OUT_W-1:0]     red_q, green_q, blue_q;
    logic                 done_q, miss_q;
    logic [7:0]           count_q;

    ccd_xy_counter #(.COORD_W(COORD_W)) u_xy (
        .clk           (clk_clk),
        .srst          (reset_reset),
        .clr_i         (start_cap),
        .fval_i        (ccd_fval),
        .lval_i        (ccd_lval),
        .dval_i        (ccd_dval),
        .x_o           (x),
        .y_o           (y),
        .sample_ok_o   (sample_ok),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= WAIT_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (!ccd_fval)  state_d = IDLE;
            IDLE:      if (frame_start) state_d = FRAME;
            FRAME:     if (frame_end)   state_d = COMMIT;
            COMMIT:                     state_d = IDLE;
            default:                    state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        start_cap = (state_q == IDLE) && frame_start;
        commit_en = (state_q == COMMIT);
    end

    // Coordinates are sampled only at frame start so mid-frame changes cannot tear a capture.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            qx_q <= '0;
            qy_q <= '0;
        end else if (start_cap) begin
            qx_q <= quad_x;
            qy_q <= quad_y;
        end
    end

    // The explicit >= guards stop the modular subtraction aliasing near the top of the range.
    assign org_x   = {qx_q, 1'b0};
    assign org_y   = {qy_q, 1'b0};
    assign rel_x   = x - org_x;
    assign rel_y   = y - org_y;
    assign in_blk  = (x >= org_x) && (y >= org_y) &&
                     (rel_x[COORD_W-1:BLK_LOG2] == '0) && (rel_y[COORD_W-1:BLK_LOG2] == '0);
    assign pix_idx = {rel_y[BLK_LOG2-1:0], rel_x[BLK_LOG2-1:0]};
    assign hit     = (state_q == FRAME) && sample_ok && in_blk && !mask_q[pix_idx];

    always_ff @(posedge clk_clk) begin
        if (reset_reset || start_cap) mask_q <= '0;
        else if (hit)                 mask_q[pix_idx] <= 1'b1;
    end

`ifdef CCD_SAMPLER_AVG_EN
    logic [DATA_W+1:0] r_acc_q, b_acc_q;
    logic [DATA_W+2:0] g_acc_q;
    logic [1:0]        bayer;

    assign bayer = {y[0], x[0]};

    always_ff @(posedge clk_clk) begin
        if (reset_reset || start_cap) begin
            r_acc_q <= '0;
            b_acc_q <= '0;
            g_acc_q <= '0;
        end else if (hit) begin
            case (bayer)
                POS_R:   r_acc_q <= r_acc_q + (DATA_W+2)'(ccd_data);
                POS_B:   b_acc_q <= b_acc_q + (DATA_W+2)'(ccd_data);
                default: g_acc_q <= g_acc_q + (DATA_W+3)'(ccd_data);
            endcase
        end
    end

    assign red_c   = OUT_W'(r_acc_q >> (DATA_W + 2 - OUT_W));
    assign blue_c  = OUT_W'(b_acc_q >> (DATA_W + 2 - OUT_W));
    assign green_c = OUT_W'(g_acc_q >> (DATA_W + 3 - OUT_W));
`else
    logic [DATA_W-1:0] pix_q [4];
    logic [DATA_W:0]   g_sum;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        always_ff @(posedge clk_clk) begin
            if (reset_reset)                       pix_q[gi] <= '0;
            else if (hit && pix_idx == 2'(gi))     pix_q[gi] <= ccd_data;
        end
    end

    // Green is truncated, not rounded.
    assign g_sum   = {1'b0, pix_q[POS_G1]} + {1'b0, pix_q[POS_G2]};
    assign red_c   = OUT_W'(pix_q[POS_R] >> (DATA_W - OUT_W));
    assign blue_c  = OUT_W'(pix_q[POS_B] >> (DATA_W - OUT_W));
    assign green_c = OUT_W'(g_sum >> (DATA_W + 1 - OUT_W));
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (commit_en) begin
                if (&mask_q) begin
                    red_q   <= red_c;
                    green_q <= green_c;
                    blue_q  <= blue_c;
                    done_q  <= 1'b1;
                    miss_q  <= 1'b0;
                    count_q <= count_q + 8'd1;
                end else begin
                    miss_q  <= 1'b1;
                end
            end
        end
    end

    assign red_out     = red_q;
    assign green_out   = green_q;
    assign blue_out    = blue_q;
    assign frame_done  = done_q;
    assign quad_miss   = miss_q;
    assign frame_count = count_q;

endmodule
